// File: rtl/pulse_cnt_pkg.sv
// Shared constants and types for the multi-channel pulse counter.
`timescale 1ns/1ps
package pulse_cnt_pkg;

  // Hard upper bound on channel count; the channel index field is 4 bits wide
  // but only this many channels are ever instantiated.
  localparam int MAX_CH = 8;

  // Global register byte addresses.
  localparam logic [9:0] IRQ_STAT_ADDR = 10'h000;
  localparam logic [9:0] PARAM_ADDR    = 10'h004;

  // Channel window: channel c lives at CH_BASE + CH_STRIDE*c.
  localparam logic [9:0] CH_BASE   = 10'h100;
  localparam int         CH_STRIDE = 16;

  // Register inside a channel window, encoded as the word offset addr[3:2]
  // (byte offsets 0x0 CR, 0x4 SR, 0x8 CNT, 0xC THR).
  typedef enum logic [1:0] {
    REG_CR  = 2'd0,
    REG_SR  = 2'd1,
    REG_CNT = 2'd2,
    REG_THR = 2'd3
  } ch_reg_e;

  // CR bit positions.
  localparam int CR_SW_BIT     = 0;
  localparam int CR_CLR_BIT    = 1;
  localparam int CR_EXT_EN_BIT = 2;
  localparam int CR_OVF_IE_BIT = 3;
  localparam int CR_THR_IE_BIT = 4;

  // SR bit positions.
  localparam int SR_OVF_BIT = 0;
  localparam int SR_THR_BIT = 1;

  // Stored CR fields, packed in CR bit order [4:1]; sw_pulse is a strobe
  // and is never stored.
  typedef struct packed {
    logic thr_ie;
    logic ovf_ie;
    logic ext_en;
    logic count_clr;
  } cr_t;

endpackage

// File: rtl/pulse_cnt_ch.sv
// One counter channel: input synchroniser, rising-edge detect, counter,
// sticky overflow/threshold flags, CR/THR registers and local read mux.
`timescale 1ns/1ps
module pulse_cnt_ch
  import pulse_cnt_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pulse_in,
  input  logic        wr,
  input  ch_reg_e     reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic             sync1_q;
  logic             sync2_q;
  logic             edge_q;
  cr_t              cr_q;
  cr_t              cr_next;
  logic             ovf_q;
  logic             thr_hit_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] thr_q;

  logic             cr_wr;
  logic             sr_wr;
  logic             thr_wr;
  logic             sw_evt;
  logic             ext_evt;
  logic [1:0]       inc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             ovf_set;
  logic             thr_set;
  logic             ovf_clr;
  logic             thr_clr;
  logic             unused_wdata;

  assign cr_wr  = wr & (reg_sel == REG_CR);
  assign sr_wr  = wr & (reg_sel == REG_SR);
  assign thr_wr = wr & (reg_sel == REG_THR);

  // Only the low bits of the bus are meaningful for any channel register.
  assign unused_wdata = ^wdata;

  // A software pulse is a CR write with bit 0 set; an external event is a
  // synchronised rising edge while external counting is enabled.
  assign sw_evt  = cr_wr & wdata[CR_SW_BIT];
  assign ext_evt = cr_q.ext_en & sync2_q & ~edge_q;
  assign inc     = {1'b0, sw_evt} + {1'b0, ext_evt};

  // The extra sum bit is the wrap indication; the +1/+2 values are the
  // intermediate counts compared against the threshold.
  assign sum    = {1'b0, cnt_q} + (CNT_W+1)'(inc);
  assign cnt_p1 = cnt_q + CNT_W'(1);
  assign cnt_p2 = cnt_q + CNT_W'(2);

  // count_clr takes its post-write value so a same-cycle clear beats a pulse.
  assign ovf_set = ~cr_next.count_clr & sum[CNT_W];
  assign thr_set = ~cr_next.count_clr &
                   (((inc != 2'd0) & (cnt_p1 == thr_q)) |
                    ((inc == 2'd2) & (cnt_p2 == thr_q)));

  // Software clears a flag by writing 0 to it; a same-cycle set still wins.
  assign ovf_clr = sr_wr & ~wdata[SR_OVF_BIT];
  assign thr_clr = sr_wr & ~wdata[SR_THR_BIT];

  // Next CR contents: write data on a CR write, otherwise hold.
  always_comb begin
    // NOTE: default assignment first keeps this combinational block latch-free.
    cr_next = cr_q;
    if (cr_wr) begin
      cr_next.count_clr = wdata[CR_CLR_BIT];
      cr_next.ext_en    = wdata[CR_EXT_EN_BIT];
      cr_next.ovf_ie    = wdata[CR_OVF_IE_BIT];
      cr_next.thr_ie    = wdata[CR_THR_IE_BIT];
    end
  end

  // Two-flop synchroniser plus the previous-level flop for edge detection;
  // it runs regardless of ext_en so re-enabling never produces a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops use non-blocking assignments so each stage samples the
    // pre-edge value of the stage before it.
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // Control, counter, sticky flags and threshold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the block holds only a handful of flops and no memory arrays,
    // so every state element gets an explicit reset value.
    if (!rst_n) begin
      cr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      thr_hit_q <= 1'b0;
      thr_q     <= '0;
    end else begin
      cr_q      <= cr_next;
      cnt_q     <= cr_next.count_clr ? '0 : sum[CNT_W-1:0];
      ovf_q     <= ovf_set | (ovf_q & ~ovf_clr);
      thr_hit_q <= thr_set | (thr_hit_q & ~thr_clr);
      if (thr_wr) begin
        thr_q <= wdata[CNT_W-1:0];
      end
    end
  end

  // Local read mux; reserved bits read as zero.
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_CR:  rdata = {27'd0, cr_q, 1'b0};
      REG_SR:  rdata = {30'd0, thr_hit_q, ovf_q};
      REG_CNT: rdata = 32'(cnt_q);
      REG_THR: rdata = 32'(thr_q);
      default: rdata = '0;
    endcase
  end

  assign irq = (ovf_q & cr_q.ovf_ie) | (thr_hit_q & cr_q.thr_ie);

endmodule

// File: rtl/pulse_counter_mc.sv
// Multi-channel pulse counter top: address decode, channel array, global
// IRQ_STAT/PARAM registers and the combinational read mux.
`timescale 1ns/1ps
module pulse_counter_mc
  import pulse_cnt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [9:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [NUM_CH-1:0] pulse_in,
  output logic              irq
);

  // Channel count actually built, clamped to the architectural maximum.
  localparam int NCH        = (NUM_CH > MAX_CH) ? MAX_CH : NUM_CH;
  localparam int STRIDE_LSB = $clog2(CH_STRIDE);
  localparam logic [31:0] PARAM_VAL = {16'd0, 8'(CNT_W), 8'(NCH)};

  logic          ch_space;
  logic [3:0]    ch_idx;
  ch_reg_e       reg_sel;
  logic [NCH-1:0] ch_hit;
  logic [NCH-1:0] irq_stat;
  logic [31:0]   ch_rdata [NCH];

  // Channel window decode: word aligned, inside the 0x100..0x1FF page.
  assign ch_space = (addr[9:8] == CH_BASE[9:8]) && (addr[1:0] == 2'b00);
  assign ch_idx   = addr[STRIDE_LSB +: 4];
  assign reg_sel  = ch_reg_e'(addr[3:2]);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign ch_hit[c] = ch_space && (ch_idx == 4'(c));

    pulse_cnt_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .pulse_in (pulse_in[c]),
      .wr       (wr_en & ch_hit[c]),
      .reg_sel  (reg_sel),
      .wdata    (wdata),
      .rdata    (ch_rdata[c]),
      .irq      (irq_stat[c])
    );
  end

  // Inputs of channels beyond the clamp are not counted.
  if (NUM_CH > NCH) begin : g_unused_pulse
    logic unused_pulse;
    assign unused_pulse = ^pulse_in[NUM_CH-1:NCH];
  end

  assign irq = |irq_stat;

  // Zero-latency read mux; anything not decoded reads zero.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (addr == IRQ_STAT_ADDR) begin
        rdata = 32'(irq_stat);
      end else if (addr == PARAM_ADDR) begin
        rdata = PARAM_VAL;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (ch_hit[c]) begin
            rdata = ch_rdata[c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_counter_mc.sv
// Directed and randomized bench for pulse_counter_mc with a behavioural
// register-level reference model.
`timescale 1ns/1ps
module tb_pulse_counter_mc;

  localparam int    NUM_CH = 4;
  localparam int    CNT_W  = 8;
  localparam longint MOD   = 64'd1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [9:0]        addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] pulse_in = '0;
  logic              irq;

  pulse_counter_mc #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .pulse_in (pulse_in),
    .irq      (irq)
  );

  always #50 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents plus the history of sampled pulse levels.
  int unsigned       m_cr  [NUM_CH];
  int unsigned       m_sr  [NUM_CH];
  int unsigned       m_thr [NUM_CH];
  longint            m_cnt [NUM_CH];
  logic [NUM_CH-1:0] hist  [$];   // hist[i] = pulse_in sampled i+1 edges ago

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ra(input int c, input int off);
    return 10'(256 + 16*c + 4*off);
  endfunction

  function automatic logic [31:0] m_irq_stat();
    logic [31:0] v = '0;
    for (int c = 0; c < NUM_CH; c++)
      v[c] = (m_sr[c][0] & m_cr[c][3]) | (m_sr[c][1] & m_cr[c][4]);
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] a);
    if (a == 10'h000) return m_irq_stat();
    if (a == 10'h004) return 32'((CNT_W << 8) | NUM_CH);
    for (int c = 0; c < NUM_CH; c++) begin
      if (a == ra(c, 0)) return m_cr[c];
      if (a == ra(c, 1)) return m_sr[c];
      if (a == ra(c, 2)) return 32'(m_cnt[c]);
      if (a == ra(c, 3)) return m_thr[c];
    end
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cr[c] = 0; m_sr[c] = 0; m_thr[c] = 0; m_cnt[c] = 0;
    end
    hist.delete();
    repeat (3) hist.push_back('0);
  endtask

  // Apply one clock edge's worth of the register rules to the model.
  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit          cr_w   = wr_en && (addr == ra(c, 0));
      bit          sr_w   = wr_en && (addr == ra(c, 1));
      bit          thr_w  = wr_en && (addr == ra(c, 3));
      int unsigned old_cr = m_cr[c];
      int unsigned new_cr = cr_w ? (wdata & 32'h1E) : old_cr;
      bit          rise   = hist[1][c] && !hist[2][c];
      int          inc    = ((cr_w && wdata[0]) ? 1 : 0) + ((old_cr[2] && rise) ? 1 : 0);
      int unsigned sr     = m_sr[c];
      if (sr_w) sr = sr & (wdata & 32'h3);
      if (new_cr[1]) begin
        m_cnt[c] = 0;
      end else begin
        longint total = m_cnt[c] + inc;
        if (total >= MOD) sr = sr | 1;
        for (int i = 1; i <= inc; i++)
          if (((m_cnt[c] + i) % MOD) == longint'(m_thr[c])) sr = sr | 2;
        m_cnt[c] = total % MOD;
      end
      if (thr_w) m_thr[c] = int'(longint'(wdata) % MOD);
      m_cr[c] = new_cr;
      m_sr[c] = sr;
    end
    hist.push_front(pulse_in);
    void'(hist.pop_back());
  endtask

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [9:0] a, input logic [31:0] exp, input string tag);
    addr = a; rd_en = 1'b1;
    #1;
    check(tag, rdata, exp);
    rd_en = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int run [NUM_CH];

  initial begin
    model_reset();
    #10 rst_n = 1'b1;

    // ---- reset in the middle of counting ----
    repeat (3) wr(ra(0, 0), 32'h1);
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      for (int off = 0; off < 4; off++)
        rd_chk(ra(c, off), 32'h0, "reset_reg");
    rd_chk(10'h000, 32'h0, "reset_irq_stat");
    check("reset_irq", {31'd0, irq}, 32'h0);
    rd_chk(10'h004, 32'h0000_0804, "param");
    addr = 10'h004; rd_en = 1'b0; #1;
    check("rd_en_low", rdata, 32'h0);
    wr(10'h010, 32'hAAAA_AAAA); rd_chk(10'h010, 32'h0, "rsvd_010");
    wr(10'h140, 32'hAAAA_AAAA); rd_chk(10'h140, 32'h0, "rsvd_140");
    wr(10'h3FC, 32'hAAAA_AAAA); rd_chk(10'h3FC, 32'h0, "rsvd_3fc");

    // ---- CR / SR reserved bits ----
    wr(ra(0, 0), 32'hFFFF_FFFF); rd_chk(ra(0, 0), 32'h1E, "cr_readback");
    wr(ra(0, 1), 32'hFFFF_FFFF); rd_chk(ra(0, 1), 32'h0, "sr_w1_noop");
    wr(ra(0, 0), 32'h0);

    // ---- software counting and level clear ----
    wr(ra(1, 0), 32'h0);
    repeat (3) wr(ra(1, 0), 32'h1);
    rd_chk(ra(1, 2), 32'd3, "sw_cnt_ch1");
    rd_chk(ra(0, 2), 32'd0, "sw_cnt_ch0");
    rd_chk(ra(2, 2), 32'd0, "sw_cnt_ch2");
    rd_chk(ra(3, 2), 32'd0, "sw_cnt_ch3");
    wr(ra(1, 0), 32'h2); rd_chk(ra(1, 2), 32'd0, "clr");
    wr(ra(1, 0), 32'h3); tick(); tick();
    rd_chk(ra(1, 2), 32'd0, "clr_beats_sw");
    rd_chk(ra(1, 0), 32'h2, "cr_sw_reads0");
    wr(ra(1, 0), 32'h0);

    // ---- external pulses on ch2 ----
    wr(ra(2, 0), 32'h4);
    repeat (4) begin
      pulse_in[2] = 1'b1; repeat (4) tick();
      pulse_in[2] = 1'b0; repeat (4) tick();
    end
    pulse_in[2] = 1'b1;
    tick(); rd_chk(ra(2, 2), 32'd4, "ext_lat0");
    tick(); rd_chk(ra(2, 2), 32'd4, "ext_lat1");
    tick(); rd_chk(ra(2, 2), 32'd5, "ext_lat2");
    tick(); pulse_in[2] = 1'b0; repeat (4) tick();
    pulse_in[2] = 1'b1; tick(); tick();
    wr(ra(2, 0), 32'h5);
    rd_chk(ra(2, 2), 32'd7, "sw_plus_ext");
    pulse_in[2] = 1'b0; repeat (3) tick();
    rd_chk(ra(2, 2), 32'd7, "ext_single_edge");
    wr(ra(2, 0), 32'h0);
    pulse_in[2] = 1'b1; repeat (4) tick();
    pulse_in[2] = 1'b0; repeat (4) tick();
    rd_chk(ra(2, 2), 32'd7, "ext_disabled");

    // ---- overflow on ch0 ----
    repeat (255) wr(ra(0, 0), 32'h1);
    rd_chk(ra(0, 2), 32'hFF, "pre_ovf");
    wr(ra(0, 3), 32'h80);
    wr(ra(0, 1), 32'h0);
    wr(ra(0, 0), 32'h4);
    pulse_in[0] = 1'b1; repeat (4) tick();
    pulse_in[0] = 1'b0; repeat (4) tick();
    rd_chk(ra(0, 2), 32'h0, "ovf_wrap");
    rd_chk(ra(0, 1), 32'h1, "ovf_flag");
    check("irq_masked", {31'd0, irq}, 32'h0);
    wr(ra(0, 0), 32'hC);
    repeat (3) begin
      check("irq_ovf_hold", {31'd0, irq}, 32'h1);
      tick();
    end
    wr(ra(0, 1), 32'h0);
    rd_chk(ra(0, 1), 32'h0, "ovf_sw_clear");
    check("irq_cleared", {31'd0, irq}, 32'h0);
    repeat (255) wr(ra(0, 0), 32'hD);
    wr(ra(0, 1), 32'h0);
    pulse_in[0] = 1'b1; tick(); tick();
    wr(ra(0, 1), 32'h0);
    rd_chk(ra(0, 1), 32'h1, "ovf_set_wins");
    rd_chk(ra(0, 2), 32'h0, "ovf_set_wins_cnt");
    check("irq_set_wins", {31'd0, irq}, 32'h1);
    pulse_in[0] = 1'b0; repeat (3) tick();
    wr(ra(0, 0), 32'h0);
    wr(ra(0, 1), 32'h0);

    // ---- threshold on ch3 ----
    wr(ra(3, 3), 32'h4);
    rd_chk(ra(3, 3), 32'h4, "thr_readback");
    wr(ra(3, 0), 32'h10);
    repeat (3) wr(ra(3, 0), 32'h11);
    rd_chk(ra(3, 1), 32'h0, "thr_not_yet");
    wr(ra(3, 0), 32'h11);
    rd_chk(ra(3, 2), 32'd4, "thr_cnt");
    rd_chk(ra(3, 1), 32'h2, "thr_hit");
    rd_chk(10'h000, 32'h8, "irq_stat_thr");
    check("irq_thr", {31'd0, irq}, 32'h1);
    wr(ra(3, 0), 32'h12);
    wr(ra(3, 1), 32'h0);
    wr(ra(3, 0), 32'h10);
    repeat (3) wr(ra(3, 0), 32'h11);
    rd_chk(ra(3, 1), 32'h0, "thr_rearm");
    wr(ra(3, 0), 32'h14);
    pulse_in[3] = 1'b1; tick(); tick();
    wr(ra(3, 0), 32'h15);
    rd_chk(ra(3, 2), 32'd5, "inc2_cnt");
    rd_chk(ra(3, 1), 32'h2, "inc2_thr_hit");
    pulse_in[3] = 1'b0; repeat (3) tick();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < NUM_CH; c++) run[c] = 10;
    for (int it = 0; it < 600; it++) begin
      logic [9:0]  a;
      logic [31:0] d;
      int          off;
      for (int c = 0; c < NUM_CH; c++)
        if (run[c] >= 2 && $urandom_range(0, 2) == 0) begin
          pulse_in[c] = ~pulse_in[c];
          run[c] = 0;
        end
      if ($urandom_range(0, 9) < 4) begin
        off = $urandom_range(0, 3);
        a   = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                           : ra($urandom_range(0, NUM_CH - 1), off);
        d   = $urandom;
        if (off == 0 && $urandom_range(0, 3) != 0) d = d & ~32'h2;
        if (off == 3) d = (d & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
        wr(a, d);
      end else begin
        tick();
      end
      for (int c = 0; c < NUM_CH; c++) run[c]++;
      case ($urandom_range(0, 3))
        0:       a = 10'($urandom_range(0, 1023));
        1:       a = 10'h000;
        default: a = ra($urandom_range(0, NUM_CH - 1), $urandom_range(0, 3));
      endcase
      rd_chk(a, m_read(a), "rand_read");
      check("rand_irq", {31'd0, irq}, {31'd0, (m_irq_stat() != 32'd0)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
